// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the four-digit multiplexed display scanner.
package display_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   // Segment vectors are indexed a..g as bits 0..6, active low.
   typedef logic [0:6] seg_t;

   localparam seg_t       SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/segment7.sv
// BCD to active-low seven-segment decoder; codes 10..15 decode to all segments off.
module segment7
   import display_scan_ctrl_pkg::*;
(
   input  logic [3:0] bcd,
   output seg_t       seg
);

   always_comb begin
      seg = SEG_OFF;
      case (bcd)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit time-multiplexed display scanner with guard blanking between slots,
// per-frame input snapshot and optional leading-zero suppression.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int unsigned CLK_DIV = 50000,
   parameter int unsigned GUARD   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] digits_in,
   input  logic        blank_lz,
   output seg_t        seg_out,
   output logic [3:0]  an_out,
   output logic [1:0]  slot_idx
);

   localparam int unsigned CntW = $clog2(CLK_DIV);
   localparam logic [CntW-1:0] GuardLast = CntW'(GUARD - 1);
   localparam logic [CntW-1:0] ShowLast  = CntW'(CLK_DIV - GUARD - 1);

   state_t            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        slot_q, slot_d;
   logic [15:0]       snap_digits_q;
   logic              snap_blz_q;
   logic              snap_load;
   seg_t              seg_q, seg_d;
   logic [3:0]        an_q, an_d;

   logic [3:0]        cur_digit;
   seg_t              dec_seg;
   logic              lz_blank;
   logic              out_of_range;
   logic [3:1]        is_zero;

   always_comb begin
      cur_digit = snap_digits_q[3:0];
      case (slot_q)
         2'd0:    cur_digit = snap_digits_q[3:0];
         2'd1:    cur_digit = snap_digits_q[7:4];
         2'd2:    cur_digit = snap_digits_q[11:8];
         default: cur_digit = snap_digits_q[15:12];
      endcase
   end

   segment7 u_segment7 (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

   assign is_zero[3]   = (snap_digits_q[15:12] == 4'd0);
   assign is_zero[2]   = (snap_digits_q[11:8] == 4'd0);
   assign is_zero[1]   = (snap_digits_q[7:4] == 4'd0);
   assign out_of_range = (cur_digit > 4'd9);

   // A digit is a leading zero only if it and every digit above it are zero.
   always_comb begin
      lz_blank = 1'b0;
      case (slot_q)
         2'd3:    lz_blank = snap_blz_q & is_zero[3];
         2'd2:    lz_blank = snap_blz_q & is_zero[3] & is_zero[2];
         2'd1:    lz_blank = snap_blz_q & is_zero[3] & is_zero[2] & is_zero[1];
         default: lz_blank = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      slot_d    = slot_q;
      snap_load = 1'b0;
      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
         slot_d  = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d   = BLANK;
               cnt_d     = '0;
               slot_d    = 2'd0;
               snap_load = 1'b1;
            end
            BLANK: begin
               if (cnt_q == GuardLast) begin
                  state_d = SHOW;
                  cnt_d   = '0;
               end
            end
            SHOW: begin
               if (cnt_q == ShowLast) begin
                  state_d   = BLANK;
                  cnt_d     = '0;
                  slot_d    = slot_q + 2'd1;
                  snap_load = (slot_q == 2'd3);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               slot_d  = 2'd0;
            end
         endcase
      end
   end

   // Outputs are computed from the next state so the registers line up with state_q.
   always_comb begin
      an_d  = AN_OFF;
      seg_d = seg_q;
      if (state_d == SHOW) begin
         an_d = ~(4'b0001 << slot_d);
      end
      if (state_d == IDLE) begin
         seg_d = SEG_OFF;
      end else if (state_q == BLANK) begin
         seg_d = (lz_blank || out_of_range) ? SEG_OFF : dec_seg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         slot_q        <= 2'd0;
         snap_digits_q <= '0;
         snap_blz_q    <= 1'b0;
         seg_q         <= SEG_OFF;
         an_q          <= AN_OFF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         if (snap_load) begin
            snap_digits_q <= digits_in;
            snap_blz_q    <= blank_lz;
         end
      end
   end

   assign seg_out  = seg_q;
   assign an_out   = an_q;
   assign slot_idx = slot_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl at CLK_DIV=8, GUARD=2.
module tb_display_scan_ctrl;
   import display_scan_ctrl_pkg::*;

   localparam int unsigned CLK_DIV = 8;
   localparam int unsigned GUARD   = 2;
   localparam int          FRAME   = 4 * CLK_DIV;

   localparam seg_t D0  = 7'b0000001;
   localparam seg_t D1  = 7'b1001111;
   localparam seg_t D2  = 7'b0010010;
   localparam seg_t D3  = 7'b0000110;
   localparam seg_t D4  = 7'b1001100;
   localparam seg_t D5  = 7'b0100100;
   localparam seg_t D6  = 7'b0100000;
   localparam seg_t D7  = 7'b0001111;
   localparam seg_t D8  = 7'b0000000;
   localparam seg_t D9  = 7'b0000100;
   localparam seg_t OFF = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] digits_in;
   logic        blank_lz;
   seg_t        seg_out;
   logic [3:0]  an_out;
   logic [1:0]  slot_idx;

   int n_vec = 0;
   int n_err = 0;
   logic mon_on = 1'b0;

   display_scan_ctrl #(
      .CLK_DIV (CLK_DIV),
      .GUARD   (GUARD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .digits_in (digits_in),
      .blank_lz  (blank_lz),
      .seg_out   (seg_out),
      .an_out    (an_out),
      .slot_idx  (slot_idx)
   );

   always #5 clk = ~clk;

   // At most one anode may be active in any cycle, whatever the scenario.
   always @(negedge clk) begin
      if (mon_on) begin
         n_vec++;
         if ($countones(~an_out) > 1) begin
            n_err++;
            $display("FAIL an_onehot t=%0t got an_out=%b required at most one 0", $time, an_out);
         end
      end
   end

   task automatic check_dark(input string name);
      n_vec++;
      if (an_out !== 4'b1111) begin
         n_err++;
         $display("FAIL %s an_out got %b required 1111", name, an_out);
      end
      n_vec++;
      if (seg_out !== OFF) begin
         n_err++;
         $display("FAIL %s seg_out got %b required 1111111", name, seg_out);
      end
      n_vec++;
      if (slot_idx !== 2'd0) begin
         n_err++;
         $display("FAIL %s slot_idx got %0d required 0", name, slot_idx);
      end
   endtask

   // Called at the negedge of the first BLANK cycle of slot 0; checks ncyc cycles.
   task automatic check_frame(input string name, input seg_t e0, input seg_t e1,
                              input seg_t e2, input seg_t e3, input int ncyc,
                              input int chg_at, input logic [15:0] chg_val);
      seg_t       exp_seg [4];
      int         slot;
      int         ph;
      logic [3:0] exp_an;
      exp_seg[0] = e0;
      exp_seg[1] = e1;
      exp_seg[2] = e2;
      exp_seg[3] = e3;
      for (int c = 0; c < ncyc; c++) begin
         slot   = (c / CLK_DIV) % 4;
         ph     = c % CLK_DIV;
         exp_an = (ph < GUARD) ? 4'b1111 : ~(4'b0001 << slot);
         n_vec++;
         if (an_out !== exp_an) begin
            n_err++;
            $display("FAIL %s an_out c=%0d got %b required %b", name, c, an_out, exp_an);
         end
         n_vec++;
         if (slot_idx !== 2'(slot)) begin
            n_err++;
            $display("FAIL %s slot_idx c=%0d got %0d required %0d", name, c, slot_idx, slot);
         end
         if (ph >= GUARD) begin
            n_vec++;
            if (seg_out !== exp_seg[slot]) begin
               n_err++;
               $display("FAIL %s seg_out c=%0d slot=%0d got %b required %b", name, c, slot,
                        seg_out, exp_seg[slot]);
            end
         end
         if (c == chg_at) digits_in = chg_val;
         @(negedge clk);
      end
   endtask

   task automatic start_scan(input logic [15:0] d, input logic blz);
      digits_in = d;
      blank_lz  = blz;
      en        = 1'b1;
      @(negedge clk);
   endtask

   task automatic stop_scan(input string name);
      en = 1'b0;
      @(negedge clk);
      check_dark(name);
      @(negedge clk);
      check_dark({name, "_hold"});
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      en        = 1'b1;
      digits_in = 16'h1234;
      blank_lz  = 1'b0;
      repeat (3) @(negedge clk);
      mon_on = 1'b1;
      check_dark("reset_over_en");
      en    = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check_dark("idle_after_reset");
   endtask

   task automatic test_basic();
      start_scan(16'h1234, 1'b0);
      check_frame("basic_1234", D4, D3, D2, D1, FRAME, -1, 16'h0);
      check_frame("basic_1234_f2", D4, D3, D2, D1, FRAME, -1, 16'h0);
      stop_scan("basic_stop");
   endtask

   task automatic test_leading_zero();
      start_scan(16'h0070, 1'b1);
      check_frame("lz_0070_on", D0, D7, OFF, OFF, FRAME, -1, 16'h0);
      stop_scan("lz_stop1");
      start_scan(16'h0070, 1'b0);
      check_frame("lz_0070_off", D0, D7, D0, D0, FRAME, -1, 16'h0);
      stop_scan("lz_stop2");
      start_scan(16'h0000, 1'b1);
      check_frame("lz_0000_on", D0, OFF, OFF, OFF, FRAME, -1, 16'h0);
      stop_scan("lz_stop3");
   endtask

   task automatic test_out_of_range();
      start_scan(16'hA000, 1'b1);
      check_frame("oor_A000", D0, D0, D0, OFF, FRAME, -1, 16'h0);
      stop_scan("oor_stop1");
      start_scan(16'h0B05, 1'b1);
      check_frame("oor_0B05", D5, D0, OFF, OFF, FRAME, -1, 16'h0);
      stop_scan("oor_stop2");
   endtask

   task automatic test_snapshot();
      start_scan(16'h1234, 1'b0);
      check_frame("snap_old", D4, D3, D2, D1, FRAME, 2 * CLK_DIV, 16'h5678);
      check_frame("snap_new", D8, D7, D6, D5, FRAME, -1, 16'h0);
      stop_scan("snap_stop");
   endtask

   task automatic test_en_drop();
      start_scan(16'h1234, 1'b0);
      check_frame("endrop_pre", D4, D3, D2, D1, CLK_DIV + GUARD + 2, -1, 16'h0);
      stop_scan("endrop_dark");
      start_scan(16'h9081, 1'b0);
      check_frame("endrop_restart", D1, D8, D0, D9, FRAME, -1, 16'h0);
      stop_scan("endrop_stop");
   endtask

   task automatic test_reset_mid_show();
      start_scan(16'h5678, 1'b0);
      check_frame("rstmid_pre", D8, D7, D6, D5, CLK_DIV + GUARD + 2, -1, 16'h0);
      rst_n = 1'b0;
      @(negedge clk);
      check_dark("rstmid_dark");
      rst_n = 1'b1;
      @(negedge clk);
      check_frame("rstmid_restart", D8, D7, D6, D5, FRAME, -1, 16'h0);
      stop_scan("rstmid_stop");
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      digits_in = 16'h0;
      blank_lz  = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_leading_zero();
      test_out_of_range();
      test_snapshot();
      test_en_drop();
      test_reset_mid_show();
      mon_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
